// File: rtl/fm_phase_gen_pkg.sv
// Shared constants, FSM state type, operator parameter payload and the
// multiplier lookup for the FM phase generator.
package fm_phase_gen_pkg;

  localparam int unsigned FM_NUM_OPS    = 36;
  localparam int unsigned FM_PHASE_BITS = 19;
  localparam int unsigned FM_OUT_BITS   = 10;

  localparam int unsigned IDX_BITS   = 6;
  localparam int unsigned RAM_DEPTH  = 64;
  localparam int unsigned FNUM_BITS  = 10;
  localparam int unsigned BLOCK_BITS = 3;
  localparam int unsigned MULT_BITS  = 4;
  localparam int unsigned MULX2_BITS = 5;
  localparam int unsigned SHIFT_BITS = 17;
  localparam int unsigned PROD_BITS  = 22;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [FNUM_BITS-1:0]  fnum;
    logic [BLOCK_BITS-1:0] block;
    logic [MULT_BITS-1:0]  mult;
    logic                  keyon;
  } op_params_t;

  // Twice the frequency multiple selected by the 4-bit multiplier code.
  function automatic logic [MULX2_BITS-1:0] fm_mulx2(input logic [MULT_BITS-1:0] mult);
    logic [MULX2_BITS-1:0] r;
    r = 5'd1;
    case (mult)
      4'd0:  r = 5'd1;
      4'd1:  r = 5'd2;
      4'd2:  r = 5'd4;
      4'd3:  r = 5'd6;
      4'd4:  r = 5'd8;
      4'd5:  r = 5'd10;
      4'd6:  r = 5'd12;
      4'd7:  r = 5'd14;
      4'd8:  r = 5'd16;
      4'd9:  r = 5'd18;
      4'd10: r = 5'd20;
      4'd11: r = 5'd20;
      4'd12: r = 5'd24;
      4'd13: r = 5'd24;
      4'd14: r = 5'd30;
      4'd15: r = 5'd30;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fm_phase_gen_inc.sv
// Combinational phase increment from fnum/block/mult.
// FM_PHASE_VIBRATO_EN adds the LFO-driven fnum offset ahead of the multiply.
module fm_phase_gen_inc
  import fm_phase_gen_pkg::*;
#(
  parameter int unsigned PHASE_BITS = FM_PHASE_BITS
) (
  input  logic [FNUM_BITS-1:0]  fnum_i,
  input  logic [BLOCK_BITS-1:0] block_i,
  input  logic [MULT_BITS-1:0]  mult_i,
`ifdef FM_PHASE_VIBRATO_EN
  input  logic [2:0]            vib_step_i,
  input  logic                  vib_deep_i,
  input  logic                  vib_en_i,
`endif
  output logic [PHASE_BITS-1:0] inc_o
);

  logic [FNUM_BITS-1:0]  fnum_eff;
  logic [SHIFT_BITS-1:0] fnum_sh;
  logic [PROD_BITS-1:0]  prod;

`ifdef FM_PHASE_VIBRATO_EN
  logic signed [5:0]  vib_hi;
  logic signed [5:0]  vib_stp;
  logic signed [5:0]  vib_prod;
  logic signed [5:0]  vib_ofs;
  logic signed [11:0] fnum_sum;

  // Offset scales with the top 3 fnum bits; shallow depth halves it.
  always_comb begin
    vib_hi   = $signed({3'b000, fnum_i[FNUM_BITS-1 -: 3]});
    vib_stp  = $signed({{3{vib_step_i[2]}}, vib_step_i});
    vib_prod = vib_hi * vib_stp;
    vib_ofs  = vib_deep_i ? vib_prod : (vib_prod >>> 1);
    fnum_sum = $signed({2'b00, fnum_i}) + $signed({{6{vib_ofs[5]}}, vib_ofs});
    if (!vib_en_i) begin
      fnum_eff = fnum_i;
    end else if (fnum_sum < 12'sd0) begin
      fnum_eff = '0;
    end else if (fnum_sum > 12'sd1023) begin
      fnum_eff = '1;
    end else begin
      fnum_eff = fnum_sum[FNUM_BITS-1:0];
    end
  end
`else
  assign fnum_eff = fnum_i;
`endif

  always_comb begin
    fnum_sh = SHIFT_BITS'(fnum_eff) << block_i;
    prod    = PROD_BITS'(fnum_sh) * PROD_BITS'(fm_mulx2(mult_i));
    inc_o   = PHASE_BITS'(prod >> 2);
  end

endmodule

// File: rtl/fm_phase_gen.sv
// FM phase generator: sweeps all operators per sample tick, accumulating
// phase in a 64-entry RAM. FM_PHASE_VIBRATO_EN enables the vibrato ports.
module fm_phase_gen
  import fm_phase_gen_pkg::*;
#(
  parameter int unsigned NUM_OPS    = FM_NUM_OPS,
  parameter int unsigned PHASE_BITS = FM_PHASE_BITS,
  parameter int unsigned OUT_BITS   = FM_OUT_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  output logic                  ready,
  output logic [IDX_BITS-1:0]   op_idx,
  input  logic [FNUM_BITS-1:0]  op_fnum,
  input  logic [BLOCK_BITS-1:0] op_block,
  input  logic [MULT_BITS-1:0]  op_mult,
  input  logic                  op_keyon,
`ifdef FM_PHASE_VIBRATO_EN
  input  logic [2:0]            vib_step,
  input  logic                  vib_deep,
  input  logic                  op_vib,
`endif
  output logic                  out_valid,
  output logic [IDX_BITS-1:0]   out_idx,
  output logic [OUT_BITS-1:0]   out_phase,
  output logic                  sweep_done
);

  state_e                state_q, state_d;
  logic [IDX_BITS-1:0]   cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic [IDX_BITS-1:0]   op_idx_q, op_idx_d;
  logic                  vld_d1_q, last_d1_q;
  logic [IDX_BITS-1:0]   idx_d1_q;
  logic [NUM_OPS-1:0]    hist_q, hist_d;
  logic                  out_valid_q, sweep_done_q;
  logic [IDX_BITS-1:0]   out_idx_q;
  logic [OUT_BITS-1:0]   out_phase_q, out_phase_d;
  logic [PHASE_BITS-1:0] ram_q [RAM_DEPTH];

  op_params_t            par;
  logic                  init_we, wr_en, key_edge;
  logic [IDX_BITS-1:0]   wr_addr;
  logic [PHASE_BITS-1:0] wr_data, rd_phase, inc, sum;

  assign par = '{fnum: op_fnum, block: op_block, mult: op_mult, keyon: op_keyon};

  fm_phase_gen_inc #(
    .PHASE_BITS (PHASE_BITS)
  ) u_inc (
    .fnum_i     (par.fnum),
    .block_i    (par.block),
    .mult_i     (par.mult),
`ifdef FM_PHASE_VIBRATO_EN
    .vib_step_i (vib_step),
    .vib_deep_i (vib_deep),
    .vib_en_i   (op_vib),
`endif
    .inc_o      (inc)
  );

  // Sweep control: INIT clears the RAM, RUN issues one operator per clock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'(RAM_DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (sample_tick) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(NUM_OPS - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    ready_d  = (state_d == ST_IDLE);
    op_idx_d = (state_d == ST_RUN) ? cnt_d : '0;
  end

  // Second stage: read, add increment (or restart on key-on edge), write back.
  always_comb begin
    rd_phase = ram_q[idx_d1_q];
    key_edge = par.keyon & ~hist_q[idx_d1_q];
    sum      = key_edge ? '0 : (rd_phase + inc);
    hist_d   = hist_q;
    if (vld_d1_q) hist_d[idx_d1_q] = par.keyon;
    wr_en       = init_we | vld_d1_q;
    wr_addr     = init_we ? cnt_q : idx_d1_q;
    wr_data     = init_we ? '0 : sum;
    out_phase_d = vld_d1_q ? sum[PHASE_BITS-1 -: OUT_BITS] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      op_idx_q     <= '0;
      vld_d1_q     <= 1'b0;
      last_d1_q    <= 1'b0;
      idx_d1_q     <= '0;
      hist_q       <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_phase_q  <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      op_idx_q     <= op_idx_d;
      vld_d1_q     <= (state_q == ST_RUN);
      last_d1_q    <= (state_q == ST_RUN) && (cnt_q == 6'(NUM_OPS - 1));
      idx_d1_q     <= cnt_q;
      hist_q       <= hist_d;
      out_valid_q  <= vld_d1_q;
      out_idx_q    <= vld_d1_q ? idx_d1_q : '0;
      out_phase_q  <= out_phase_d;
      sweep_done_q <= last_d1_q;
    end
  end

  // Phase RAM has no reset; INIT zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (wr_en) ram_q[wr_addr] <= wr_data;
  end

  assign ready      = ready_q;
  assign op_idx     = op_idx_q;
  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_phase  = out_phase_q;
  assign sweep_done = sweep_done_q;

endmodule
